// File: rtl/branch_resolver_if.sv
// branch_resolver_if: request/result handshake between sequencer, branch resolver and PC-mux control
interface branch_resolver_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] ir;
  logic [15:0] pc;
  logic        res_valid;
  logic        res_ready;
  logic        ben;
  logic        redirect;
  logic [15:0] target;
  modport master (
    output req_valid, ir, pc, res_ready,
    input  req_ready, res_valid, ben, redirect, target
  );
  modport slave (
    input  req_valid, ir, pc, res_ready,
    output req_ready, res_valid, ben, redirect, target
  );
endinterface

// File: rtl/branch_resolver.sv
// branch_resolver: LC-3b BEN evaluation and branch target generation with a saturating taken counter
module branch_resolver #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  branch_resolver_if.slave   bus,
  input  logic               n_in,
  input  logic               z_in,
  input  logic               p_in,
  input  logic               ld_cc,
  output logic [CNT_W-1:0]   taken_count
);
  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;
  state_t      state;
  logic [15:0] ir_q;
  logic [15:0] pc_q;
  logic        ben_q;
  logic        redirect_q;
  logic [15:0] target_q;
  logic        ben_next;
  logic [15:0] target_next;
  assign ben_next    = |(ir_q[11:9] & {n_in, z_in, p_in});
  assign target_next = pc_q + {{6{ir_q[8]}}, ir_q[8:0], 1'b0};
  assign bus.req_ready = (state == IDLE);
  assign bus.res_valid = (state == HOLD);
  assign bus.ben       = ben_q;
  assign bus.redirect  = redirect_q;
  assign bus.target    = target_q;
  // Negedge state updates line up with the CCR flops; ld_cc low means CCs are still settling
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ir_q        <= '0;
      pc_q        <= '0;
      ben_q       <= 1'b0;
      redirect_q  <= 1'b0;
      target_q    <= '0;
      taken_count <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          ir_q  <= bus.ir;
          pc_q  <= bus.pc;
          state <= EVAL;
        end
        EVAL: if (ld_cc) begin
          ben_q      <= ben_next;
          redirect_q <= ben_next & (ir_q[15:12] == 4'b0000);
          target_q   <= target_next;
          state      <= HOLD;
        end
        HOLD: if (bus.res_ready) begin
          state <= IDLE;
          if (redirect_q && !(&taken_count)) taken_count <= taken_count + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vectors with a scoreboard queue checked by an independent monitor
module tb_branch_resolver;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       n_in = 1'b0, z_in = 1'b0, p_in = 1'b0, ld_cc = 1'b1;
  logic [7:0] taken_count;
  int checks = 0;
  int errors = 0;
  int cnt = 0;
  typedef struct {
    logic        ben;
    logic        redirect;
    logic [15:0] target;
    int          cnt;
  } exp_t;
  exp_t sb[$];
  branch_resolver_if bus();
  branch_resolver #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .n_in(n_in), .z_in(z_in), .p_in(p_in), .ld_cc(ld_cc),
    .taken_count(taken_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  // Monitor: outputs are sampled 1 time unit after posedge, half a period away from the active negedge
  initial begin
    forever begin
      @(posedge clk); #1;
      if (reset && bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ben", bus.ben, e.ben);
          chk("redirect", bus.redirect, e.redirect);
          chk("target", bus.target, e.target);
          chk("taken_count_pre", taken_count, e.cnt);
        end
      end
    end
  end
  task automatic run(input logic [15:0] ir, input logic [15:0] pc, input logic [2:0] nzp,
                     input int stall, input logic [2:0] nzp_late,
                     input logic eb, input logic er, input logic [15:0] et, input logic full);
    exp_t e;
    @(posedge clk);
    bus.req_valid = 1'b1; bus.ir = ir; bus.pc = pc; bus.res_ready = 1'b1;
    {n_in, z_in, p_in} = nzp;
    ld_cc = (stall == 0);
    e.ben = eb; e.redirect = er; e.target = et; e.cnt = cnt;
    sb.push_back(e);
    @(negedge clk);
    @(posedge clk);
    bus.req_valid = 1'b0;
    if (full) begin
      chk("req_ready_eval", bus.req_ready, 0);
      chk("res_valid_eval", bus.res_valid, 0);
    end
    if (stall > 0) {n_in, z_in, p_in} = nzp_late;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      @(posedge clk);
      chk("res_valid_stall", bus.res_valid, 0);
      if (i == stall - 1) ld_cc = 1'b1;
    end
    @(negedge clk);
    @(posedge clk);
    if (full) chk("res_valid_hold", bus.res_valid, 1);
    @(negedge clk);
    if (er && cnt != 255) cnt++;
    @(posedge clk);
    if (full) begin
      chk("taken_count_post", taken_count, cnt);
      chk("req_ready_idle", bus.req_ready, 1);
    end
  endtask
  initial begin
    logic [15:0] t0;
    logic        b0;
    bus.req_valid = 1'b0; bus.ir = '0; bus.pc = '0; bus.res_ready = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_ben", bus.ben, 0);
    chk("rst_redirect", bus.redirect, 0);
    chk("rst_target", bus.target, 16'h0000);
    chk("rst_count", taken_count, 0);
    @(posedge clk);
    reset = 1'b1;
    run(16'h0A05, 16'h3000, 3'b100, 0, 3'b000, 1, 1, 16'h300A, 1);
    run(16'h0A05, 16'h3000, 3'b010, 0, 3'b000, 0, 0, 16'h300A, 1);
    run(16'h0FFF, 16'h0000, 3'b010, 0, 3'b000, 1, 1, 16'hFFFE, 1);
    run(16'h0000, 16'h1234, 3'b111, 0, 3'b000, 0, 0, 16'h1234, 1);
    run(16'h1A05, 16'h3000, 3'b100, 0, 3'b000, 1, 0, 16'h300A, 1);
    run(16'h0F00, 16'h4000, 3'b001, 0, 3'b000, 1, 1, 16'h3E00, 1);
    run(16'h0405, 16'h3000, 3'b000, 2, 3'b010, 1, 1, 16'h300A, 1);
    // Backpressure then asynchronous reset mid-HOLD; this result is dropped, so no scoreboard entry
    @(posedge clk);
    bus.req_valid = 1'b1; bus.ir = 16'h0A05; bus.pc = 16'h5000; bus.res_ready = 1'b0;
    {n_in, z_in, p_in} = 3'b100; ld_cc = 1'b1;
    @(negedge clk);
    @(posedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    chk("bp_res_valid", bus.res_valid, 1);
    chk("bp_target", bus.target, 16'h500A);
    t0 = bus.target; b0 = bus.ben;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      @(posedge clk);
      chk("bp_hold_valid", bus.res_valid, 1);
      chk("bp_hold_ready", bus.req_ready, 0);
      chk("bp_hold_target", bus.target, t0);
      chk("bp_hold_ben", bus.ben, b0);
    end
    #2 reset = 1'b0;
    #1;
    chk("arst_res_valid", bus.res_valid, 0);
    chk("arst_count", taken_count, 0);
    chk("arst_req_ready", bus.req_ready, 1);
    chk("arst_ben", bus.ben, 0);
    chk("arst_target", bus.target, 16'h0000);
    cnt = 0;
    @(posedge clk);
    reset = 1'b1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 260; i++)
      run(16'h0E01, 16'h0100, 3'b010, 0, 3'b000, 1, 1, 16'h0102, 0);
    chk("sat_count", taken_count, 8'hFF);
    @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
